// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 hex keypad scanner.
//   state_t    : scanner FSM states
//   COL_*      : active-low one-hot column drive patterns
//   col_drive  : column index -> column drive pattern
//   key_map    : (row, column) -> hex key code
//   one_low    : true when exactly one active-low row is asserted
//   low_row    : index of the asserted row (meaningful only when one_low)
// -----------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] COL_0 = 4'b1110;
   localparam logic [3:0] COL_1 = 4'b1101;
   localparam logic [3:0] COL_2 = 4'b1011;
   localparam logic [3:0] COL_3 = 4'b0111;

   function automatic logic [3:0] col_drive(input logic [1:0] col);
      logic [3:0] drive;
      case (col)
         2'd0:    drive = COL_0;
         2'd1:    drive = COL_1;
         2'd2:    drive = COL_2;
         default: drive = COL_3;
      endcase
      return drive;
   endfunction

   // Physical legend of the keypad, row-major.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   function automatic logic one_low(input logic [3:0] rows_n);
      return $onehot(~rows_n);
   endfunction

   function automatic logic [1:0] low_row(input logic [3:0] rows_n);
      logic [1:0] idx;
      casez (~rows_n)
         4'b???1: idx = 2'd0;
         4'b??10: idx = 2'd1;
         4'b?100: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// 4-bit two-flop synchronizer for the asynchronous keypad rows. Resets to
// 4'b1111 so an idle (pulled-up) keypad is seen during and right after reset.
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   d      in  asynchronous input
//   q      out synchronized output (2 cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value; blocking here would collapse the two stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Column-scanning controller for a 4x4 hex keypad with press and release
// debouncing and a two-digit history for the seven-segment display path.
//   clk        in  system clock
//   reset      in  synchronous, active-high reset
//   row_n      in  keypad rows, asynchronous, active-low
//   col_n      out column drive, one-hot active-low
//   key_code   out hex value of the last accepted key
//   key_valid  out one-cycle pulse per accepted press
//   key_held   out high while the accepted key is considered pressed
//   digit_new  out most recent accepted digit
//   digit_old  out digit accepted before digit_new
// -----------------------------------------------------------------------------
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 48000,
   parameter int DEBOUNCE_CYCLES = 960000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int SC_W = $clog2(SCAN_CYCLES);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

   localparam logic [SC_W-1:0] DWELL_LAST = SC_W'(SCAN_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0] rows_s;

   state_t          state_q,     state_d;
   logic [1:0]      col_idx_q,   col_idx_d;
   logic [1:0]      row_idx_q,   row_idx_d;
   logic [SC_W-1:0] dwell_q,     dwell_d;
   logic [DB_W-1:0] db_cnt_q,    db_cnt_d;
   logic [3:0]      col_n_q,     col_n_d;
   logic [3:0]      key_code_q,  key_code_d;
   logic            key_valid_q, key_valid_d;
   logic            key_held_q,  key_held_d;
   logic [3:0]      digit_new_q, digit_new_d;
   logic [3:0]      digit_old_q, digit_old_d;

   logic            row_low;
   logic [3:0]      code_now;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row_n),
      .q     (rows_s)
   );

   // The latched row is the only one that matters once a key is captured.
   assign row_low  = ~rows_s[row_idx_q];
   assign code_now = key_map(row_idx_q, col_idx_q);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      row_idx_d   = row_idx_q;
      dwell_d     = dwell_q;
      db_cnt_d    = db_cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      digit_new_d = digit_new_q;
      digit_old_d = digit_old_q;

      case (state_q)
         SCAN: begin
            // Rows are only trusted on the last dwell cycle, after settling.
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (one_low(rows_s)) begin
                  row_idx_d = low_row(rows_s);
                  db_cnt_d  = '0;
                  state_d   = DB_PRESS;
               end else begin
                  // Idle column or ghosting/multi-key: keep scanning.
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               dwell_d = dwell_q + SC_W'(1);
            end
         end

         DB_PRESS: begin
            if (!row_low) begin
               state_d   = SCAN;
               col_idx_d = col_idx_q + 2'd1;
               dwell_d   = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = HELD;
               key_code_d  = code_now;
               digit_old_d = digit_new_q;
               digit_new_d = code_now;
               key_valid_d = 1'b1;
               key_held_d  = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end

         HELD: begin
            // Column stays frozen; other keys cannot steal the scanner.
            if (!row_low) begin
               db_cnt_d = '0;
               state_d  = DB_RELEASE;
            end
         end

         DB_RELEASE: begin
            if (row_low) begin
               db_cnt_d = '0;
               state_d  = HELD;
            end else if (db_cnt_q == DB_LAST) begin
               state_d    = SCAN;
               col_idx_d  = col_idx_q + 2'd1;
               dwell_d    = '0;
               key_held_d = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase

      col_n_d = col_drive(col_idx_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SCAN;
         col_idx_q   <= 2'd0;
         row_idx_q   <= 2'd0;
         dwell_q     <= '0;
         db_cnt_q    <= '0;
         col_n_q     <= COL_0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         digit_new_q <= 4'h0;
         digit_old_q <= 4'h0;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         row_idx_q   <= row_idx_d;
         dwell_q     <= dwell_d;
         db_cnt_q    <= db_cnt_d;
         col_n_q     <= col_n_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         digit_new_q <= digit_new_d;
         digit_old_q <= digit_old_d;
      end
   end

   assign col_n     = col_n_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign digit_new = digit_new_q;
   assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Drives a behavioural 4x4 key matrix (pressed[row][col] shorts a row to the
// driven column) and checks the scanner through a scoreboard: each press that
// must be accepted pushes its expected code and digit history; a monitor pops
// and compares on every key_valid pulse.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int SC = 4;
   localparam int DB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic [3:0] digit_new;
   logic [3:0] digit_old;

   keypad_scanner #(
      .SCAN_CYCLES     (SC),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .digit_new (digit_new),
      .digit_old (digit_old)
   );

   always #5 clk = ~clk;

   // Key matrix: a pressed key pulls its row low while its column is driven.
   bit pressed [4][4];

   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r][c] && !col_n[c]) row_n[r] = 1'b0;
   end

   // Printed legend of the keypad.
   int key_tab [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

   typedef struct packed {
      logic [3:0] code;
      logic [3:0] dnew;
      logic [3:0] dold;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [3:0] m_new = 4'h0;
   logic [3:0] m_old = 4'h0;
   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;
   int         exp_pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_key(input int r, input int c);
      exp_t e;
      m_old  = m_new;
      m_new  = 4'(key_tab[r][c]);
      e.code = m_new;
      e.dnew = m_new;
      e.dold = m_old;
      sb_q.push_back(e);
      exp_pulses++;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_all();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            pressed[r][c] = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_col_n"},     col_n,     4'b1110);
      check({tag, "_key_code"},  key_code,  4'h0);
      check({tag, "_digit_new"}, digit_new, 4'h0);
      check({tag, "_digit_old"}, digit_old, 4'h0);
      check({tag, "_key_valid"}, key_valid, 1'b0);
      check({tag, "_key_held"},  key_held,  1'b0);
   endtask

   // Monitor: every key_valid pulse must match the oldest expected press.
   always @(negedge clk) begin
      if (!reset && key_valid) begin
         pulses++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key_valid: got code %0h expected no pulse", key_code);
         end else begin
            mon_e = sb_q.pop_front();
            check("key_code",  key_code,  mon_e.code);
            check("digit_new", digit_new, mon_e.dnew);
            check("digit_old", digit_old, mon_e.dold);
            check("key_held_on_accept", key_held, 1'b1);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: got no finish expected finish within 2ms");
      $fatal(1, "timeout");
   end

   int  r, c, n;
   bit  long_p;
   bit  held_dropped;
   bit  seen [4];

   initial begin
      release_all();

      // Reset state.
      reset = 1'b1;
      cycles(3);
      check_reset_outputs("reset");
      reset = 1'b0;

      // Clean press: row 1, column 2 -> 6.
      cycles(5);
      pressed[1][2] = 1'b1;
      expect_key(1, 2);
      cycles(45);
      check("clean_pulses", pulses, exp_pulses);
      check("clean_held", key_held, 1'b1);
      check("clean_col_frozen", col_n, 4'b1011);
      release_all();
      cycles(30);
      check("clean_released", key_held, 1'b0);

      // Bounce: row 0, column 0 toggling every 5 cycles, then stable -> 1.
      pressed[0][0] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cycles(5);
         pressed[0][0] = !pressed[0][0];
      end
      cycles(20);
      check("bounce_no_pulse", pulses, exp_pulses);
      pressed[0][0] = 1'b1;
      expect_key(0, 0);
      cycles(45);
      check("bounce_stable_pulse", pulses, exp_pulses);
      release_all();
      cycles(30);

      // Sequence: 5 then A.
      pressed[1][1] = 1'b1;
      expect_key(1, 1);
      cycles(45);
      release_all();
      cycles(30);
      pressed[0][3] = 1'b1;
      expect_key(0, 3);
      cycles(45);
      check("seq_digit_new", digit_new, 4'hA);
      check("seq_digit_old", digit_old, 4'h5);
      check("seq_pulses", pulses, exp_pulses);
      release_all();
      cycles(30);

      // Ghost: rows 0 and 2 low on column 1; scanning must keep rotating.
      pressed[0][1] = 1'b1;
      pressed[2][1] = 1'b1;
      for (int k = 0; k < 4; k++) seen[k] = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) if (!col_n[j]) seen[j] = 1'b1;
      end
      check("ghost_scan_rotates", {28'd0, seen[3], seen[2], seen[1], seen[0]}, 32'hF);
      check("ghost_no_pulse", pulses, exp_pulses);
      check("ghost_not_held", key_held, 1'b0);
      release_all();
      cycles(10);

      // Second key while held is ignored; short release bounce stays held.
      pressed[2][2] = 1'b1;
      expect_key(2, 2);
      cycles(45);
      pressed[1][0] = 1'b1;
      cycles(40);
      check("second_key_ignored", pulses, exp_pulses);
      check("second_key_col_frozen", col_n, 4'b1011);
      pressed[1][0] = 1'b0;
      held_dropped = 1'b0;
      pressed[2][2] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (!key_held) held_dropped = 1'b1;
      end
      pressed[2][2] = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (!key_held) held_dropped = 1'b1;
      end
      check("release_bounce_held", held_dropped, 1'b0);
      check("release_bounce_no_pulse", pulses, exp_pulses);
      release_all();
      cycles(30);
      check("release_done", key_held, 1'b0);

      // Randomized presses: short ones must be rejected, long ones accepted.
      for (int i = 0; i < 30; i++) begin
         r      = int'($urandom_range(3));
         c      = int'($urandom_range(3));
         long_p = 1'($urandom_range(1));
         cycles(int'($urandom_range(7)));
         pressed[r][c] = 1'b1;
         if (long_p) begin
            expect_key(r, c);
            n = int'($urandom_range(60, 45));
         end else begin
            n = int'($urandom_range(12, 1));
         end
         cycles(n);
         pressed[r][c] = 1'b0;
         cycles(30);
         check("rand_pulses", pulses, exp_pulses);
         check("rand_idle", key_held, 1'b0);
      end

      // Reset while in DB_PRESS (debounce counter at 10): no pulse, all cleared.
      reset = 1'b1;
      release_all();
      pressed[2][0] = 1'b1;
      cycles(3);
      reset = 1'b0;
      cycles(14);
      check("dbpress_col_frozen", col_n, 4'b1110);
      reset = 1'b1;
      release_all();
      sb_q.delete();
      m_new = 4'h0;
      m_old = 4'h0;
      cycles(3);
      check_reset_outputs("midreset");
      reset = 1'b0;
      cycles(40);
      check("midreset_no_pulse", pulses, exp_pulses);
      check("midreset_digit_new", digit_new, 4'h0);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
